led_sequencer: RTL and testbench

//   Parametrised LED pattern sequencer for iCE40 boards. It steps an N-bit LED

---
 rtl/led_sequencer.sv | 122 ++++++++++++
 tb/tb_led_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// LED pattern sequencer: steps an N-bit pattern (rotate-left/right, bounce, hold)
// at a programmable rate, plus an independent square-wave blink channel.
module led_sequencer #(
  parameter int unsigned       N_LEDS       = 4,
  parameter int unsigned       STEP_DIV     = 12000000,
  parameter int unsigned       BLINK_DIV    = 12500000,
  parameter logic [N_LEDS-1:0] INIT_PATTERN = N_LEDS'(4'b1001)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              pause,
  input  logic              load_en,
  input  logic [N_LEDS-1:0] load_pattern,
  output logic [N_LEDS-1:0] leds,
  output logic              blink,
  output logic              tick
);

  localparam int unsigned STEP_W  = $clog2(STEP_DIV);
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [1:0] MODE_ROT_L  = 2'b00;
  localparam logic [1:0] MODE_ROT_R  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  logic [N_LEDS-1:0]  leds_q, leds_d;
  logic               blink_q, blink_d;
  logic               tick_q, tick_d;
  logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  dir_e               dir_q, dir_d;

  logic [N_LEDS-1:0] shl, shr;
  logic              lose;

  assign leds  = leds_q;
  assign blink = blink_q;
  assign tick  = tick_q;

  // Zero-fill shifts used by bounce; bit i moves to i+1 for a left shift.
  assign shl  = {leds_q[N_LEDS-2:0], 1'b0};
  assign shr  = {1'b0, leds_q[N_LEDS-1:1]};
  assign lose = (dir_q == DIR_LEFT) ? leds_q[N_LEDS-1] : leds_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q      <= INIT_PATTERN;
      blink_q     <= 1'b0;
      tick_q      <= 1'b0;
      step_cnt_q  <= '0;
      blink_cnt_q <= '0;
      dir_q       <= DIR_LEFT;
    end else begin
      leds_q      <= leds_d;
      blink_q     <= blink_d;
      tick_q      <= tick_d;
      step_cnt_q  <= step_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      dir_q       <= dir_d;
    end
  end

  // Step counter, load and pattern update; load beats a coincident step.
  always_comb begin
    leds_d     = leds_q;
    dir_d      = dir_q;
    step_cnt_d = step_cnt_q;
    tick_d     = 1'b0;

    if (load_en) begin
      leds_d     = load_pattern;
      step_cnt_d = '0;
      dir_d      = DIR_LEFT;
    end else if (!pause) begin
      if (step_cnt_q == STEP_LAST) begin
        step_cnt_d = '0;
        tick_d     = 1'b1;
        case (mode)
          MODE_ROT_L: leds_d = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
          MODE_ROT_R: leds_d = {leds_q[0], leds_q[N_LEDS-1:1]};
          MODE_BOUNCE: begin
            if (!lose) begin
              leds_d = (dir_q == DIR_LEFT) ? shl : shr;
            end else if (dir_q == DIR_LEFT) begin
              // Reverse; move only if the opposite end is free.
              dir_d = DIR_RIGHT;
              if (!leds_q[0]) leds_d = shr;
            end else begin
              dir_d = DIR_LEFT;
              if (!leds_q[N_LEDS-1]) leds_d = shl;
            end
          end
          MODE_HOLD: leds_d = leds_q;
          default:   leds_d = leds_q;
        endcase
      end else begin
        step_cnt_d = step_cnt_q + STEP_W'(1);
      end
    end
  end

  // Free-running blink divider.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_d     = blink_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: directed scenarios plus randomized
// traffic, compared every cycle against a behavioural model.
module tb_led_sequencer;

  localparam int unsigned N    = 4;
  localparam int unsigned SD   = 4;
  localparam int unsigned BD   = 5;
  localparam int          MASK = (1 << N) - 1;
  localparam int          INIT = 9;

  logic       clk = 1'b0;
  logic       rst, pause, load_en;
  logic [1:0] mode;
  logic [3:0] load_pattern;
  logic [3:0] leds;
  logic       blink, tick;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_leds, m_dir, m_sc, m_blink, m_tick, k_since_rst;

  logic [3:0] exp_rl [4];
  logic [3:0] exp_rr [4];
  logic [3:0] exp_bn [7];

  always #5 clk = ~clk;

  led_sequencer #(
    .N_LEDS      (N),
    .STEP_DIV    (SD),
    .BLINK_DIV   (BD),
    .INIT_PATTERN(4'b1001)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .pause       (pause),
    .load_en     (load_en),
    .load_pattern(load_pattern),
    .leds        (leds),
    .blink       (blink),
    .tick        (tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int do_step(input int l, input int md, inout int dir);
    int top_free, bot_free;
    top_free = ((l >> (N - 1)) & 1) == 0;
    bot_free = (l & 1) == 0;
    case (md)
      0: return ((l * 2) & MASK) | (l >> (N - 1));
      1: return (l >> 1) | ((l & 1) << (N - 1));
      2: begin
        if (dir == 0) begin
          if (top_free) return (l * 2) & MASK;
          dir = 1;
          return bot_free ? (l / 2) : l;
        end
        if (bot_free) return l / 2;
        dir = 0;
        return top_free ? ((l * 2) & MASK) : l;
      end
      default: return l;
    endcase
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_leds = INIT; m_dir = 0; m_sc = 0; m_blink = 0; m_tick = 0;
      k_since_rst = 0;
    end else begin
      k_since_rst++;
      m_blink = (k_since_rst / BD) % 2;
      m_tick  = 0;
      if (load_en) begin
        m_leds = int'(load_pattern); m_sc = 0; m_dir = 0;
      end else if (!pause) begin
        m_sc++;
        if (m_sc == SD) begin
          m_sc   = 0;
          m_tick = 1;
          m_leds = do_step(m_leds, int'(mode), m_dir);
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("leds", 32'(leds), m_leds);
    check("blink", 32'(blink), m_blink);
    check("tick", 32'(tick), m_tick);
  endtask

  task automatic do_reset();
    rst = 1'b1; load_en = 1'b0; pause = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    exp_rl = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
    exp_rr = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
    exp_bn = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    rst = 1'b1; mode = 2'b00; pause = 1'b0; load_en = 1'b0; load_pattern = 4'b0000;
    m_leds = INIT; m_dir = 0; m_sc = 0; m_blink = 0; m_tick = 0; k_since_rst = 0;

    // Reset state
    cycle();
    do_reset();
    check("rst_leds", 32'(leds), 32'h9);
    check("rst_blink", 32'(blink), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);

    // Rotate left from reset
    mode = 2'b00;
    for (int i = 1; i <= 16; i++) begin
      cycle();
      check("t1_tick", 32'(tick), 32'((i % 4) == 0));
      if ((i % 4) == 0) check("t1_leds", 32'(leds), 32'(exp_rl[i/4-1]));
    end

    // Rotate right from reset
    do_reset();
    mode = 2'b01;
    for (int i = 1; i <= 16; i++) begin
      cycle();
      if ((i % 4) == 0) check("t2_leds", 32'(leds), 32'(exp_rr[i/4-1]));
    end

    // Bounce from 0001, then a pattern stuck at both ends
    mode = 2'b10; load_en = 1'b1; load_pattern = 4'b0001;
    cycle();
    load_en = 1'b0;
    for (int i = 1; i <= 28; i++) begin
      cycle();
      if ((i % 4) == 0) check("t3_bounce", 32'(leds), 32'(exp_bn[i/4-1]));
    end
    load_en = 1'b1; load_pattern = 4'b1001;
    cycle();
    load_en = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if ((i % 4) == 0) begin
        check("t3_hold_leds", 32'(leds), 32'h9);
        check("t3_hold_tick", 32'(tick), 32'h1);
      end
    end

    // Pause mid-count resumes from the held count
    do_reset();
    mode = 2'b00;
    cycle(); cycle();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t4_pause_leds", 32'(leds), 32'h9);
      check("t4_pause_tick", 32'(tick), 32'h0);
      check("t4_blink", 32'(blink), 32'((k_since_rst / 5) % 2));
    end
    pause = 1'b0;
    cycle();
    check("t4_resume_wait", 32'(tick), 32'h0);
    cycle();
    check("t4_resume_tick", 32'(tick), 32'h1);
    check("t4_resume_leds", 32'(leds), 32'h3);

    // Load on the step cycle suppresses tick and restarts the period
    do_reset();
    mode = 2'b00;
    cycle(); cycle(); cycle();
    load_en = 1'b1; load_pattern = 4'b0101;
    cycle();
    load_en = 1'b0;
    check("t5_load_leds", 32'(leds), 32'h5);
    check("t5_load_tick", 32'(tick), 32'h0);
    cycle(); cycle(); cycle();
    check("t5_no_tick", 32'(tick), 32'h0);
    cycle();
    check("t5_tick", 32'(tick), 32'h1);
    check("t5_leds", 32'(leds), 32'ha);

    // Reset mid-bounce while moving right with blink high
    do_reset();
    mode = 2'b10;
    load_en = 1'b1; load_pattern = 4'b1000;
    cycle();
    load_en = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("t6_pre_leds", 32'(leds), 32'h4);
    check("t6_pre_blink", 32'(blink), 32'h1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_rst_leds", 32'(leds), 32'h9);
    check("t6_rst_blink", 32'(blink), 32'h0);
    check("t6_rst_tick", 32'(tick), 32'h0);
    load_en = 1'b1; load_pattern = 4'b0010;
    cycle();
    load_en = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("t6_left", 32'(leds), 32'h4);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      load_en      = ($urandom_range(0, 15) == 0);
      pause        = ($urandom_range(0, 3) == 0);
      load_pattern = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
